// File: rtl/ahb2apb_mux_bridge_pkg.sv
// Shared encodings for the AHB-Lite to multi-completer APB bridge:
// HTRANS/HRESP values and the bridge FSM state type.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb2apb_mux_bridge_if.sv
// AHB-Lite target side and APB requester side of the bridge in one bundle.
// slave = bridge view, master = view of the AHB master plus APB completers.
interface ahb2apb_mux_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 4
);
  logic                          hsel;
  logic [ADDR_WIDTH-1:0]         haddr;
  logic [1:0]                    htrans;
  logic [2:0]                    hsize;
  logic                          hwrite;
  logic                          hready;
  logic [DATA_WIDTH-1:0]         hwdata;
  logic                          hreadyout;
  logic                          hresp;
  logic [DATA_WIDTH-1:0]         hrdata;

  logic [ADDR_WIDTH-1:0]         paddr;
  logic [NUM_SLV-1:0]            psel;
  logic                          penable;
  logic                          pwrite;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [DATA_WIDTH/8-1:0]       pstrb;
  logic [NUM_SLV*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLV-1:0]            pready;
  logic [NUM_SLV-1:0]            pslverr;

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hready, hwdata,
    input  prdata, pready, pslverr,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hready, hwdata,
    output prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );

endinterface

// File: rtl/ahb2apb_strb_gen.sv
// Byte-strobe generator: a byte is enabled when it lies in the same
// naturally aligned 2**hsize chunk as the address; full-width and larger sizes enable all.
module ahb2apb_strb_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                        hsize,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   addr_lsb,
  output logic [DATA_WIDTH/8-1:0]           strb
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB_W = $clog2(NB);

  always_comb begin
    strb = '0;
    for (int b = 0; b < NB; b++) begin
      if (int'(hsize) >= LSB_W) strb[b] = 1'b1;
      else                      strb[b] = ((b >> hsize) == (int'(addr_lsb) >> hsize));
    end
  end

endmodule

// File: rtl/ahb2apb_mux_bridge.sv
// AHB-Lite to APB bridge with integrated decoder for NUM_SLV completers.
// Optional ACCESS-phase timeout is compiled in with AHB2APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a new address phase, OKAY
// WDATA  | write data phase, latch hwdata
// SETUP  | APB setup, psel high
// ACCESS | APB access, wait for pready of selected completer
// ERR1   | first ERROR cycle, hreadyout low
// ERR2   | second ERROR cycle, hreadyout high
module ahb2apb_mux_bridge
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLV        = 4,
  parameter int SLV_ADDR_BITS  = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb2apb_mux_bridge_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB_W = $clog2(NB);
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || NUM_SLV < 1 || NUM_SLV > 16 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ahb2apb_mux_bridge: unsupported parameter set");
  end

  state_t                  state;
  logic [IDX_W-1:0]        idx_q;
  logic                    hreadyout_q, hresp_q, penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0]   hrdata_q, pwdata_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [NUM_SLV-1:0]      psel_q;
  logic [NB-1:0]           pstrb_q, strb_w;

  logic [IDX_W-1:0]        hidx;
  logic                    mapped, accept, sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_SLV-1:0] oh;
    oh = '0;
    for (int s = 0; s < NUM_SLV; s++) oh[s] = (int'(i) == s);
    return oh;
  endfunction

  assign hidx      = bus.haddr[SLV_ADDR_BITS +: IDX_W];
  assign mapped    = (int'(hidx) < NUM_SLV);
  assign accept    = bus.hsel & bus.hready & bus.htrans[1] & (state == ST_IDLE);
  assign sel_ready = bus.pready[idx_q];
  assign sel_err   = bus.pslverr[idx_q];
  assign sel_rdata = bus.prdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  ahb2apb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_gen (
    .hsize    (bus.hsize),
    .addr_lsb (bus.haddr[LSB_W-1:0]),
    .strb     (strb_w)
  );

`ifdef AHB2APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
`ifdef AHB2APB_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q       <= hidx;
            paddr_q     <= ADDR_WIDTH'(bus.haddr[SLV_ADDR_BITS-1:0]);
            pwrite_q    <= bus.hwrite;
            pstrb_q     <= bus.hwrite ? strb_w : '0;
            hreadyout_q <= 1'b0;
            if (!mapped) begin
              hresp_q <= HRESP_ERROR;
              state   <= ST_ERR1;
            end else if (bus.hwrite) begin
              state   <= ST_WDATA;
            end else begin
              psel_q  <= onehot(hidx);
              state   <= ST_SETUP;
`ifdef AHB2APB_TIMEOUT_EN
              to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
        end
        ST_WDATA: begin
          pwdata_q <= bus.hwdata;
          psel_q   <= onehot(idx_q);
          state    <= ST_SETUP;
`ifdef AHB2APB_TIMEOUT_EN
          to_cnt   <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (sel_err) begin
              hresp_q <= HRESP_ERROR;
              state   <= ST_ERR1;
            end else begin
              hrdata_q    <= sel_rdata;
              hreadyout_q <= 1'b1;
              state       <= ST_IDLE;
            end
          end
`ifdef AHB2APB_TIMEOUT_EN
          else if (to_cnt == '0) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            hresp_q   <= HRESP_ERROR;
            state     <= ST_ERR1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        ST_ERR1: begin
          hreadyout_q <= 1'b1;
          state       <= ST_ERR2;
        end
        ST_ERR2: begin
          hresp_q <= HRESP_OKAY;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_mux_bridge.sv
// Bench for ahb2apb_mux_bridge with three completers (index 3 unmapped);
// directed table, random transfers against a transfer-level model, corner sequences.
module tb_ahb2apb_mux_bridge;
  import ahb2apb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int SAB = 12;
  localparam int TO  = 6;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          low;
    bit          err;
    int          exp_waits;
    bit          exp_err;
    logic [3:0]  exp_strb;
  } vec_t;

  logic hclk = 1'b0;
  logic hreset;
  int   errs = 0;
  int   checks = 0;

  always #5 hclk = ~hclk;

  ahb2apb_mux_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS)) bus ();

  ahb2apb_mux_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS),
    .SLV_ADDR_BITS(SAB), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input int idx, input int low, input bit err);
    if (idx >= NS) return 1'b1;
`ifdef AHB2APB_TIMEOUT_EN
    if (low >= TO) return 1'b1;
`endif
    return err;
  endfunction

  // hreadyout-low cycles: pre-access cycles, access cycles, one ERR1 on error
  function automatic int model_waits(input bit wr, input int idx, input int low, input bit err);
    int pre;
    if (idx >= NS) return 1;
    pre = wr ? 2 : 1;
`ifdef AHB2APB_TIMEOUT_EN
    if (low >= TO) return pre + TO + 1;
`endif
    return pre + low + 1 + (err ? 1 : 0);
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] addr);
    int nbytes, lsb;
    if (size >= 3'd2) return 4'hF;
    nbytes = 1 << size;
    lsb    = int'(addr[1:0]);
    lsb    = lsb - (lsb % nbytes);
    return 4'(((1 << nbytes) - 1) << lsb);
  endfunction

  // Entered at a negedge with the bridge idle; returns at the negedge where the bridge is idle again.
  task automatic xfer(input vec_t v);
    int idx, waits, acc;
    bit mapped, done, bad, saw_psel, hresp_last;
    logic [NS-1:0] oh;
    idx = int'(v.addr[13:12]);
    mapped = (idx < NS);
    oh = '0;
    if (mapped) oh[idx] = 1'b1;
    waits = 0; acc = 0; done = 0; bad = 0; saw_psel = 0; hresp_last = 0;
    bus.hsel = 1'b1; bus.hready = 1'b1; bus.htrans = HTRANS_NONSEQ;
    bus.haddr = v.addr; bus.hwrite = v.wr; bus.hsize = v.size;
    @(posedge hclk); #1;
    bus.htrans = HTRANS_IDLE; bus.haddr = $urandom; bus.hwrite = 1'($urandom);
    bus.hsize = 3'($urandom); bus.hwdata = v.wdata;
    for (int c = 0; c < 64; c++) begin
      @(negedge hclk);
      if (bus.hreadyout) begin done = 1; break; end
      waits++;
      hresp_last = bus.hresp;
      if (c >= 1) bus.hwdata = $urandom;
      if (bus.psel != '0) begin
        saw_psel = 1;
        if (bus.psel !== oh || bus.paddr !== (v.addr & 32'hFFF) || bus.pwrite !== v.wr ||
            bus.pstrb !== v.exp_strb || (v.wr && bus.pwdata !== v.wdata)) bad = 1;
      end
      bus.pready  = NS'($urandom);
      bus.pslverr = NS'($urandom);
      bus.prdata  = {$urandom, $urandom, $urandom};
      if (mapped && bus.penable) begin
        acc++;
        bus.pready[idx]  = (acc > v.low);
        bus.pslverr[idx] = v.err;
        bus.prdata[idx*DW +: DW] = v.rdata;
      end
    end
    chk("completed", done, 1);
    chk("wait_states", waits, v.exp_waits);
    chk("hresp_final", bus.hresp, v.exp_err);
    if (mapped) chk("apb_stable", bad, 0);
    else        chk("psel_unmapped", saw_psel, 0);
    if (v.exp_err) begin
      chk("err1_hresp", hresp_last, 1);
      @(negedge hclk);
      chk("post_err_idle", {bus.hreadyout, bus.hresp}, 2'b10);
    end else if (!v.wr) begin
      chk("hrdata", bus.hrdata, v.rdata);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vec_t r;
    int   idx;
    bit   ok;

    vecs[0] = '{1'b0, 32'h2010, 3'd2, 32'h0,       32'hCAFEF00D, 0, 1'b0, 2, 1'b0, 4'h0};
    vecs[1] = '{1'b1, 32'h0003, 3'd0, 32'hAB000000, 32'h0,       0, 1'b0, 3, 1'b0, 4'h8};
    vecs[2] = '{1'b0, 32'h1004, 3'd2, 32'h0,       32'h5A5A1234, 4, 1'b0, 6, 1'b0, 4'h0};
    vecs[3] = '{1'b1, 32'h1008, 3'd2, 32'h11223344, 32'h0,       0, 1'b1, 4, 1'b1, 4'hF};
    vecs[4] = '{1'b0, 32'h3000, 3'd2, 32'h0,       32'hDEADDEAD, 0, 1'b0, 1, 1'b1, 4'h0};
    vecs[5] = '{1'b1, 32'h2006, 3'd1, 32'hBEEF0000, 32'h0,       0, 1'b0, 3, 1'b0, 4'hC};
    vecs[6] = '{1'b0, 32'h0000, 3'd2, 32'h0,       32'h77777777, 2, 1'b1, 5, 1'b1, 4'h0};
    vecs[7] = '{1'b1, 32'h1001, 3'd3, 32'h0F0F0F0F, 32'h0,       0, 1'b0, 3, 1'b0, 4'hF};
    vecs[8] = '{1'b0, 32'h2FFC, 3'd2, 32'h0,       32'h0BADBEEF, 1, 1'b0, 3, 1'b0, 4'h0};
    vecs[9] = '{1'b1, 32'h0005, 3'd0, 32'h0000CD00, 32'h0,       1, 1'b0, 4, 1'b0, 4'h2};

    bus.hsel = 0; bus.haddr = '0; bus.htrans = HTRANS_IDLE; bus.hsize = '0;
    bus.hwrite = 0; bus.hready = 1; bus.hwdata = '0;
    bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
    hreset = 1'b1;
    repeat (3) @(negedge hclk);
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_hresp", bus.hresp, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pstrb", bus.pstrb, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_hrdata", bus.hrdata, 0);
    hreset = 1'b0;
    @(negedge hclk);

    bus.hsel = 1; bus.htrans = HTRANS_BUSY;
    @(negedge hclk);
    chk("busy_zero_wait", {bus.hreadyout, bus.hresp, bus.psel}, {2'b10, 3'b000});
    bus.htrans = HTRANS_IDLE;

    for (int i = 0; i < 10; i++) xfer(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 3);
      r.wr    = 1'($urandom);
      r.size  = 3'($urandom_range(0, 3));
      r.addr  = $urandom;
      r.addr[13:12] = 2'(idx);
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.low   = $urandom_range(0, 3);
      r.err   = ($urandom_range(0, 7) == 0);
      r.exp_err   = model_err(idx, r.low, r.err);
      r.exp_waits = model_waits(r.wr, idx, r.low, r.err);
      r.exp_strb  = r.wr ? model_strb(r.size, r.addr) : 4'h0;
      xfer(r);
    end

    // a new address phase presented during ERR2 must be ignored
    bus.hsel = 1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h3000; bus.hwrite = 0;
    @(posedge hclk); #1;
    bus.htrans = HTRANS_IDLE;
    @(negedge hclk);
    @(negedge hclk);
    chk("err2_state", {bus.hreadyout, bus.hresp}, 2'b11);
    bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h0000;
    @(posedge hclk); #1;
    bus.htrans = HTRANS_IDLE;
    ok = 1;
    repeat (3) begin
      @(negedge hclk);
      if (bus.psel != '0 || !bus.hreadyout) ok = 0;
    end
    chk("err2_no_accept", ok, 1);

`ifdef AHB2APB_TIMEOUT_EN
    r = '{1'b0, 32'h2000, 3'd2, 32'h0, 32'h12345678, 0, 1'b0, 2, 1'b0, 4'h0};
    xfer(r);
    r = '{1'b0, 32'h1000, 3'd2, 32'h0, 32'h99999999, 1000, 1'b0, 0, 1'b1, 4'h0};
    r.exp_waits = model_waits(r.wr, 1, r.low, r.err);
    xfer(r);
    chk("timeout_hrdata_kept", bus.hrdata, 32'h12345678);
`endif

    // reset in the middle of ACCESS abandons the APB cycle
    bus.pready = '0; bus.pslverr = '0;
    bus.hsel = 1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h1000; bus.hwrite = 0; bus.hsize = 3'd2;
    @(posedge hclk); #1;
    bus.htrans = HTRANS_IDLE;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge hclk);
      if (bus.penable) begin ok = 1; break; end
    end
    chk("reached_access", ok, 1);
    hreset = 1'b1;
    @(negedge hclk);
    chk("midrst_psel", bus.psel, 0);
    chk("midrst_penable", bus.penable, 0);
    chk("midrst_ready_resp", {bus.hreadyout, bus.hresp}, 2'b10);
    hreset = 1'b0;
    bus.pready = '1;
    repeat (2) @(negedge hclk);
    chk("after_rst_idle", {bus.psel, bus.penable, bus.hreadyout}, {3'b000, 1'b0, 1'b1});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
